// File: rtl/adder_result_buffer_pkg.sv
// rtl/adder_result_buffer_pkg.sv - shared state encoding and result record layout for the adder result buffer
package adder_result_buffer_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_ONE   = ST_ONE,
      S_TWO   = ST_TWO
   } skid_state_t;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   // Record layout: {ovf, carry, sum[WIDTH-1:0]}
   function automatic int res_w(input int width);
      return width + 2;
   endfunction

   function automatic int carry_pos(input int width);
      return width;
   endfunction

   function automatic int ovf_pos(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/adder_result_buffer_skid.sv
// rtl/adder_result_buffer_skid.sv - result_skid_reg: generic two-entry valid/ready skid register
module result_skid_reg
   import adder_result_buffer_pkg::*;
#(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_s_tdata,
   input  logic         i_s_tvalid,
   output logic         o_s_tready,
   output logic [W-1:0] o_m_tdata,
   output logic         o_m_tvalid,
   input  logic         i_m_tready
);

   skid_state_t  r_state;
   logic [W-1:0] r_head;
   logic [W-1:0] r_skid;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         w_accept;
   logic         w_pop;

   assign w_accept = i_s_tvalid & r_in_ready;
   assign w_pop    = r_out_valid & i_m_tready;

   // Ready and valid are registered alongside the state so neither path is combinational.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_EMPTY;
         r_head      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_head      <= i_s_tdata;
                  r_state     <= S_ONE;
                  r_out_valid <= 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && !w_pop) begin
                  r_skid     <= i_s_tdata;
                  r_state    <= S_TWO;
                  r_in_ready <= 1'b0;
               end else if (!w_accept && w_pop) begin
                  r_state     <= S_EMPTY;
                  r_out_valid <= 1'b0;
               end else if (w_accept && w_pop) begin
                  r_head <= i_s_tdata;
               end
            end
            S_TWO: begin
               if (w_pop) begin
                  r_head     <= r_skid;
                  r_state    <= S_ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_s_tready = r_in_ready;
   assign o_m_tdata  = r_head;
   assign o_m_tvalid = r_out_valid;

endmodule

// File: rtl/adder_result_buffer.sv
// rtl/adder_result_buffer.sv - registered two-deep output stage for the ripple adder with sticky flags and counter
// Optional output saturation is compiled in with ADDER_RESULT_SAT_EN.
module adder_result_buffer
   import adder_result_buffer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_carry,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   input  logic             clear_flags,
   output logic             sticky_carry,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] result_cnt
);

   localparam int RES_W = res_w(WIDTH);
   localparam int C_POS = carry_pos(WIDTH);
   localparam int V_POS = ovf_pos(WIDTH);

   logic [RES_W-1:0] w_in_res;
   logic [RES_W-1:0] w_head;
   logic [WIDTH-1:0] w_head_sum;
   logic             w_ready;
   logic             w_accept;
   logic             r_sticky_carry;
   logic             r_sticky_ovf;
   logic [CNT_W-1:0] r_cnt;

   assign w_in_res = {in_ovf, in_carry, in_sum};
   assign w_accept = in_valid & w_ready;

   result_skid_reg #(.W(RES_W)) u_skid (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_s_tdata  (w_in_res),
      .i_s_tvalid (in_valid),
      .o_s_tready (w_ready),
      .o_m_tdata  (w_head),
      .o_m_tvalid (out_valid),
      .i_m_tready (out_ready)
   );

   // A set in the same cycle as clear_flags takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sticky_carry <= 1'b0;
         r_sticky_ovf   <= 1'b0;
         r_cnt          <= '0;
      end else begin
         if (w_accept && in_carry)  r_sticky_carry <= 1'b1;
         else if (clear_flags)      r_sticky_carry <= 1'b0;
         if (w_accept && in_ovf)    r_sticky_ovf <= 1'b1;
         else if (clear_flags)      r_sticky_ovf <= 1'b0;
         if (w_accept)              r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_head_sum = w_head[WIDTH-1:0];

`ifdef ADDER_RESULT_SAT_EN
   logic [WIDTH-1:0] w_sat_sum;
   // Sum MSB set with overflow means two positives wrapped negative: clamp to max positive.
   assign w_sat_sum = w_head_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
   assign out_sum   = w_head[V_POS] ? w_sat_sum : w_head_sum;
`else
   assign out_sum   = w_head_sum;
`endif

   assign in_ready     = w_ready;
   assign out_carry    = w_head[C_POS];
   assign out_ovf      = w_head[V_POS];
   assign sticky_carry = r_sticky_carry;
   assign sticky_ovf   = r_sticky_ovf;
   assign result_cnt   = r_cnt;

endmodule

// File: tb/tb_adder_result_buffer.sv
// tb/tb_adder_result_buffer.sv - self-checking bench for adder_result_buffer (table vectors plus scoreboard)
`timescale 1ns/1ps
module tb_adder_result_buffer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_sum = '0;
   logic       in_carry = 1'b0;
   logic       in_ovf = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_sum;
   logic       out_carry;
   logic       out_ovf;
   logic       clear_flags = 1'b0;
   logic       sticky_carry;
   logic       sticky_ovf;
   logic [7:0] result_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [3:0] sum;
      logic       carry;
      logic       ovf;
   } res_t;

   typedef struct {
      logic [3:0] in_sum;
      logic       in_c;
      logic       in_v;
      logic [3:0] exp_raw;
      logic [3:0] exp_sat;
   } vec_t;

   res_t       sb[$];
   logic [3:0] drv_exp_sum = '0;

   adder_result_buffer #(.WIDTH(4), .CNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sum       (in_sum),
      .in_carry     (in_carry),
      .in_ovf       (in_ovf),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_carry    (out_carry),
      .out_ovf      (out_ovf),
      .clear_flags  (clear_flags),
      .sticky_carry (sticky_carry),
      .sticky_ovf   (sticky_ovf),
      .result_cnt   (result_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] pick(input logic [3:0] raw, input logic [3:0] sat);
`ifdef ADDER_RESULT_SAT_EN
      return sat;
`else
      return raw;
`endif
   endfunction

   // Scoreboard: push on accept, pop and compare on output handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_pop", 1, 0);
            end else begin
               res_t e;
               e = sb.pop_front();
               check("sb_sum", out_sum, e.sum);
               check("sb_carry", out_carry, e.carry);
               check("sb_ovf", out_ovf, e.ovf);
            end
         end
         if (in_valid && in_ready) sb.push_back('{drv_exp_sum, in_carry, in_ovf});
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      clear_flags = 1'b0;
      reset = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Holds the input until accepted; returns at posedge+1 of the accepting edge.
   task automatic push_one(input logic [3:0] s, input logic c, input logic v, input logic [3:0] e);
      logic acc;
      int   k;
      in_sum = s; in_carry = c; in_ovf = v; drv_exp_sum = e; in_valid = 1'b1;
      acc = 1'b0;
      for (k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("push_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      out_ready = 1'b1;
      for (k = 0; k < 20 && (out_valid || sb.size() != 0); k++) @(posedge clk);
      #1;
      check("drain_empty", sb.size(), 0);
   endtask

   vec_t vecs[8];
   bit   ready_ok;

   initial begin
      vecs[0] = '{4'b0110, 1'b0, 1'b0, 4'b0110, 4'b0110};
      vecs[1] = '{4'b1100, 1'b0, 1'b1, 4'b1100, 4'b0111};
      vecs[2] = '{4'b0110, 1'b1, 1'b1, 4'b0110, 4'b1000};
      vecs[3] = '{4'b0011, 1'b1, 1'b0, 4'b0011, 4'b0011};
      vecs[4] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 4'b1111};
      vecs[5] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0111};
      vecs[6] = '{4'b0111, 1'b0, 1'b1, 4'b0111, 4'b1000};
      vecs[7] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000};

      do_reset();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_flags", {out_carry, out_ovf}, 0);
      check("rst_sticky", {sticky_carry, sticky_ovf}, 0);
      check("rst_cnt", result_cnt, 0);
      @(posedge clk); #1;

      // Single result, latency 1
      out_ready = 1'b1;
      push_one(4'b0110, 1'b0, 1'b0, 4'b0110);
      @(negedge clk);
      check("single_valid", out_valid, 1);
      check("single_sum", out_sum, 4'b0110);
      check("single_flags", {out_carry, out_ovf}, 0);
      check("single_cnt", result_cnt, 1);
      @(posedge clk); #1;

      // Table vectors, one at a time
      for (int i = 0; i < 8; i++) begin
         push_one(vecs[i].in_sum, vecs[i].in_c, vecs[i].in_v, pick(vecs[i].exp_raw, vecs[i].exp_sat));
         @(negedge clk);
         check($sformatf("vec%0d_sum", i), out_sum, pick(vecs[i].exp_raw, vecs[i].exp_sat));
         check($sformatf("vec%0d_carry", i), out_carry, vecs[i].in_c);
         check($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].in_v);
         @(posedge clk); #1;
      end
      check("vec_cnt", result_cnt, 9);
      drain();

      // Backpressure: two entries, then ordered drain
      do_reset();
      out_ready = 1'b0;
      push_one(4'b0101, 1'b0, 1'b0, 4'b0101);
      push_one(4'b0011, 1'b0, 1'b0, 4'b0011);
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_head_sum", out_sum, 4'b0101);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bp_hold_sum", out_sum, 4'b0101);
      check("bp_hold_valid", out_valid, 1);
      check("bp_queue", sb.size(), 2);
      @(posedge clk); #1;
      drain();
      check("bp_empty_valid", out_valid, 0);
      check("bp_empty_hold", out_sum, 4'b0011);
      check("bp_cnt", result_cnt, 2);

      // Sticky flags, clear vs set priority
      do_reset();
      out_ready = 1'b1;
      push_one(4'b0011, 1'b1, 1'b0, 4'b0011);
      @(negedge clk);
      check("stk_carry_set", sticky_carry, 1);
      check("stk_ovf_clear", sticky_ovf, 0);
      @(posedge clk); #1;
      clear_flags = 1'b1;
      push_one(4'b1100, 1'b0, 1'b1, pick(4'b1100, 4'b0111));
      clear_flags = 1'b0;
      @(negedge clk);
      check("stk_carry_cleared", sticky_carry, 0);
      check("stk_ovf_set", sticky_ovf, 1);
      @(posedge clk); #1;
      clear_flags = 1'b1;
      push_one(4'b0011, 1'b1, 1'b0, 4'b0011);
      clear_flags = 1'b0;
      @(negedge clk);
      check("stk_set_wins", sticky_carry, 1);
      check("stk_ovf_cleared", sticky_ovf, 0);
      @(posedge clk); #1;
      drain();

      // Counter wrap, 256 back-to-back accepts
      do_reset();
      out_ready = 1'b1;
      ready_ok = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] s;
         s = 4'(i);
         if (!in_ready) ready_ok = 1'b0;
         push_one(s, 1'b0, 1'b0, s);
         if (i == 254) check("wrap_cnt_255", result_cnt, 255);
      end
      check("wrap_in_ready", ready_ok, 1);
      check("wrap_cnt_0", result_cnt, 0);
      drain();

      // Reset mid-stream while holding two entries
      out_ready = 1'b0;
      push_one(4'b1010, 1'b1, 1'b1, pick(4'b1010, 4'b0111));
      push_one(4'b0001, 1'b0, 1'b0, 4'b0001);
      @(negedge clk);
      check("mid_two_in_ready", in_ready, 0);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_cnt", result_cnt, 0);
      check("mid_rst_sticky", {sticky_carry, sticky_ovf}, 0);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_no_replay", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
